// File: rtl/core_pkg.sv
// Shared constants for the 64-bit core: datapath width and
// load funct3 encodings used by the memory/writeback path.
package core_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: lane select, sign/zero extension and
// misaligned/illegal load detection. Purely combinational.
module load_formatter
    import core_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            fault
);

    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_h;
    logic [XLEN-1:0] w_w;

    assign w_b = rdata >> {addr, 3'b000};
    assign w_h = rdata >> {addr[2:1], 4'b0000};
    assign w_w = rdata >> {addr[2], 5'b00000};

    always_comb begin
        data  = '0;
        fault = 1'b0;
        case (funct3)
            F3_LB: data = {{56{w_b[7]}}, w_b[7:0]};
            F3_LBU: data = {56'd0, w_b[7:0]};
            F3_LH: begin
                data  = {{48{w_h[15]}}, w_h[15:0]};
                fault = addr[0];
            end
            F3_LHU: begin
                data  = {48'd0, w_h[15:0]};
                fault = addr[0];
            end
            F3_LW: begin
                data  = {{32{w_w[31]}}, w_w[31:0]};
                fault = |addr[1:0];
            end
            F3_LWU: begin
                data  = {32'd0, w_w[31:0]};
                fault = |addr[1:0];
            end
            F3_LD: begin
                data  = rdata;
                fault = |addr;
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formatted load/ALU result, register
// file write port, load fault pulse and retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN      = core_pkg::XLEN,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_reg_write,
    input  logic                 in_mem_to_reg,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rd,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_read_data,
    output logic                 wb_valid,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 load_fault,
    output logic [XLEN-1:0]      fault_addr,
    output logic [INSTRET_W-1:0] instret
);

    logic [XLEN-1:0]      w_fmt_data;
    logic                 w_fmt_fault;
    logic                 w_fault;
    logic                 w_en;
    logic [XLEN-1:0]      w_data;

    logic                 r_valid;
    logic                 r_en;
    logic [4:0]           r_rd;
    logic [XLEN-1:0]      r_data;
    logic                 r_fault;
    logic [XLEN-1:0]      r_faddr;
    logic [INSTRET_W-1:0] r_instret;

    load_formatter u_fmt (
        .funct3 (in_funct3),
        .addr   (in_alu_result[2:0]),
        .rdata  (in_read_data),
        .data   (w_fmt_data),
        .fault  (w_fmt_fault)
    );

    assign w_fault = in_mem_to_reg & w_fmt_fault;
    assign w_en    = in_valid & in_reg_write
                   & (in_rd != 5'd0) & ~w_fault;
    assign w_data  = !in_mem_to_reg ? in_alu_result
                   : (w_fault ? '0 : w_fmt_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_en      <= 1'b0;
            r_rd      <= '0;
            r_data    <= '0;
            r_fault   <= 1'b0;
            r_faddr   <= '0;
            r_instret <= '0;
        end else begin
            // the WB instruction retires as it leaves the register
            if (r_valid && !stall && !flush)
                r_instret <= r_instret + 1'b1;
            if (flush) begin
                r_valid <= 1'b0;
                r_en    <= 1'b0;
                r_fault <= 1'b0;
            end else if (stall) begin
                r_fault <= 1'b0;
            end else begin
                r_valid <= in_valid;
                r_en    <= w_en;
                r_rd    <= in_rd;
                r_data  <= w_data;
                r_fault <= in_valid & w_fault;
                if (in_valid && w_fault)
                    r_faddr <= in_alu_result;
            end
        end
    end

    assign in_ready   = ~stall;
    assign wb_valid   = r_valid;
    assign wb_en      = r_en;
    assign wb_rd      = r_rd;
    assign wb_data    = r_data;
    assign load_fault = r_fault;
    assign fault_addr = r_faddr;
    assign instret    = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus
// randomized traffic against a behavioural reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [63:0] in_alu_result;
    logic [63:0] in_read_data;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        load_fault;
    logic [63:0] fault_addr;
    logic [63:0] instret;

    int n_chk = 0;
    int n_err = 0;

    bit          m_valid;
    bit          m_en;
    logic [4:0]  m_rd;
    logic [63:0] m_data;
    bit          m_fault;
    logic [63:0] m_faddr;
    logic [63:0] m_instret;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .stall         (stall),
        .flush         (flush),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_funct3     (in_funct3),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_read_data  (in_read_data),
        .wb_valid      (wb_valid),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .load_fault    (load_fault),
        .fault_addr    (fault_addr),
        .instret       (instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference load semantics: size/sign table and shift arithmetic.
    function automatic void ref_load(input logic [2:0] f3,
                                     input logic [63:0] a,
                                     input logic [63:0] d,
                                     output logic [63:0] r,
                                     output bit bad);
        int sz;
        bit sgn;
        int lane;
        logic [63:0] mask;
        lane = int'(a[2:0]);
        sgn  = (f3 < 3'd4);
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2, 3'd6: sz = 4;
            default:    sz = 8;
        endcase
        bad = (f3 == 3'd7) || ((lane % sz) != 0);
        r = d >> (8 * lane);
        if (sz < 8) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            r = r & mask;
            if (sgn && r[8*sz-1]) r = r | ~mask;
        end
        if (bad) r = '0;
    endfunction

    task automatic cyc(input bit v, input bit rw, input bit m2r,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] a, input logic [63:0] d,
                       input bit st, input bit fl, input bit rn);
        logic [63:0] ld;
        bit bad;
        bit flt;
        rst_n = rn; in_valid = v; in_reg_write = rw;
        in_mem_to_reg = m2r; in_funct3 = f3; in_rd = rd;
        in_alu_result = a; in_read_data = d;
        stall = st; flush = fl;
        @(posedge clk);
        ref_load(f3, a, d, ld, bad);
        flt = m2r && bad;
        if (!rn) begin
            m_valid = 0; m_en = 0; m_rd = 0; m_data = 0;
            m_fault = 0; m_faddr = 0; m_instret = 0;
        end else begin
            if (m_valid && !st && !fl) m_instret = m_instret + 1;
            if (fl) begin
                m_valid = 0; m_en = 0; m_fault = 0;
            end else if (st) begin
                m_fault = 0;
            end else begin
                m_valid = v;
                m_rd    = rd;
                m_en    = v && rw && rd != 0 && !flt;
                m_data  = m2r ? ld : a;
                m_fault = v && flt;
                if (m_fault) m_faddr = a;
            end
        end
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, !st});
        chk("wb_valid", {63'd0, wb_valid}, {63'd0, m_valid});
        chk("wb_en", {63'd0, wb_en}, {63'd0, m_en});
        chk("load_fault", {63'd0, load_fault}, {63'd0, m_fault});
        chk("instret", instret, m_instret);
        if (m_valid) begin
            chk("wb_rd", {59'd0, wb_rd}, {59'd0, m_rd});
            chk("wb_data", wb_data, m_data);
        end
        if (m_fault) chk("fault_addr", fault_addr, m_faddr);
    endtask

    task automatic idle(input bit st, input bit fl);
        cyc(0, 0, 0, 3'd0, 5'd0, 64'd0, 64'd0, st, fl, 1);
    endtask

    initial begin
        logic [63:0] a;
        logic [2:0]  f;
        rst_n = 0; in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0;
        in_funct3 = 0; in_rd = 0; in_alu_result = 0; in_read_data = 0;
        stall = 0; flush = 0;
        m_valid = 0; m_en = 0; m_rd = 0; m_data = 0;
        m_fault = 0; m_faddr = 0; m_instret = 0;

        cyc(0, 0, 0, 3'd0, 5'd0, 64'd0, 64'd0, 1, 1, 0);
        chk("rst_data", wb_data, 64'd0);
        chk("rst_faddr", fault_addr, 64'd0);

        cyc(1, 1, 1, 3'd0, 5'd5, 64'h1003, 64'h0011223380556677, 0, 0, 1);
        chk("lb", wb_data, 64'hFFFFFFFFFFFFFF80);
        cyc(1, 1, 1, 3'd4, 5'd5, 64'h1003, 64'h0011223380556677, 0, 0, 1);
        chk("lbu", wb_data, 64'h0000000000000080);
        cyc(1, 1, 1, 3'd2, 5'd6, 64'h2004, 64'h80000001DEADBEEF, 0, 0, 1);
        chk("lw", wb_data, 64'hFFFFFFFF80000001);
        cyc(1, 1, 1, 3'd6, 5'd6, 64'h2004, 64'h80000001DEADBEEF, 0, 0, 1);
        chk("lwu", wb_data, 64'h0000000080000001);
        cyc(1, 1, 1, 3'd3, 5'd6, 64'h2000, 64'h80000001DEADBEEF, 0, 0, 1);
        chk("ld", wb_data, 64'h80000001DEADBEEF);

        cyc(1, 1, 1, 3'd1, 5'd9, 64'h3001, 64'h1234, 0, 0, 1);
        chk("lh_fault", {63'd0, load_fault}, 64'd1);
        chk("lh_faddr", fault_addr, 64'h3001);
        idle(0, 0);
        chk("fault_once", {63'd0, load_fault}, 64'd0);
        cyc(1, 1, 1, 3'd7, 5'd9, 64'h3008, 64'h1234, 0, 0, 1);
        chk("ill_faddr", fault_addr, 64'h3008);

        cyc(1, 1, 0, 3'd5, 5'd0, 64'h55, 64'h0, 0, 0, 1);
        chk("x0_en", {63'd0, wb_en}, 64'd0);
        cyc(1, 1, 0, 3'd5, 5'd7, 64'h55, 64'h0, 0, 0, 1);
        chk("alu_data", wb_data, 64'h55);

        cyc(1, 1, 1, 3'd1, 5'd3, 64'h4003, 64'hAAAA, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 1, 3'd0, 5'd4, 64'h9, 64'hFF, 1, 0, 1);
        cyc(1, 1, 1, 3'd0, 5'd4, 64'h9, 64'hFF, 1, 1, 1);
        chk("flush_valid", {63'd0, wb_valid}, 64'd0);

        cyc(1, 1, 0, 3'd0, 5'd8, 64'h77, 64'h0, 0, 0, 1);
        @(negedge clk);
        force dut.r_instret = 64'hFFFFFFFFFFFFFFFF;
        #1;
        release dut.r_instret;
        m_instret = 64'hFFFFFFFFFFFFFFFF;
        idle(0, 0);
        chk("wrap", instret, 64'd0);

        cyc(1, 1, 0, 3'd0, 5'd8, 64'h77, 64'h0, 1, 0, 0);
        chk("midrst_valid", {63'd0, wb_valid}, 64'd0);

        for (int i = 0; i < 2000; i++) begin
            f = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) a[2:0] = 3'd0;
            cyc(1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 4) != 0),
                1'($urandom_range(0, 1)),
                f, 5'($urandom_range(0, 31)), a,
                {$urandom, $urandom},
                1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 59) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-to-writeback stage of the 64-bit RISC-V core; sits directly downstream of the data-memory access stage.
- Registers the MEM result (one-entry MEM/WB pipeline register) and formats load data: byte-lane select, sign/zero extension.
- Drives the register-file write port, flags misaligned or illegal loads, and keeps the retired-instruction counter (instret).

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  MEM stage presents a valid instruction.
- in_ready  output  1  stage accepts this cycle; equals !stall.
- stall  input  1  hold the MEM/WB register contents.
- flush  input  1  kill the MEM/WB register contents.
- in_reg_write  input  1  instruction writes rd.
- in_mem_to_reg  input  1  1 = load result; 0 = ALU result.
- in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal.
- in_rd  input  5  destination register.
- in_alu_result  input  XLEN  ALU result; this is also the load address.
- in_read_data  input  XLEN  naturally aligned doubleword containing the address, from data memory.
- wb_valid  output  1  registered valid instruction in WB.
- wb_en  output  1  register-file write enable.
- wb_rd  output  5  register-file write index.
- wb_data  output  XLEN  register-file write data.
- load_fault  output  1  one-cycle pulse: misaligned or illegal load retired.
- fault_addr  output  XLEN  faulting address; valid while load_fault=1.
- instret  output  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0 at posedge): wb_valid=0, wb_en=0, wb_rd=0, wb_data=0, load_fault=0, fault_addr=0, instret=0. Reset overrides stall and flush.
- Latency: 1 cycle. Inputs captured at posedge appear on the wb_* outputs in the following cycle. Load formatting happens before the register, so outputs are fully registered.
- Update priority each posedge: reset > flush > stall > capture.
  - flush: wb_valid=0, wb_en=0, load_fault=0; wb_rd and wb_data hold; instret does not increment.
  - stall (no flush): all registers hold. load_fault is forced to 0 after its first cycle, so it never re-pulses.
  - capture: wb_valid=in_valid; all other fields computed as below. When in_valid=0, wb_en=0 and load_fault=0.
- Byte lane: lane = in_alu_result[2:0].
  - LB/LBU take byte[lane].
  - LH/LHU take half[lane[2:1]].
  - LW/LWU take word[lane[2]].
  - LD takes the full doubleword.
  - LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend.
- Misaligned load: LH/LHU with addr[0]!=0; LW/LWU with addr[1:0]!=0; LD with addr[2:0]!=0.
- Fault handling, when in_mem_to_reg=1 and the load is misaligned or funct3=111:
  - load_fault=1, fault_addr=in_alu_result, wb_en=0, wb_data=0.
  - wb_valid still 1, and the instruction counts as retired.
- Non-load (in_mem_to_reg=0): wb_data=in_alu_result; funct3 is ignored.
- wb_en = in_valid & in_reg_write & (in_rd!=0) & !fault. A write to x0 is suppressed but the instruction still retires.
- instret increments by 1 on every posedge where the registered wb_valid=1 and the stage is not stalled. It wraps modulo 2^INSTRET_W.
- Simultaneous flush and stall: flush wins.
- Reset asserted mid-stall: all state clears on that edge.

Decomposition:
- Shared package core_pkg holds:
  - XLEN.
  - funct3 load encodings: F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU.
- Sub-module load_formatter: combinational lane select, extension and misalignment/illegal detect. Inputs: funct3, addr[2:0], rdata. Outputs: data, fault.
- mem_wb_stage contains the pipeline register, the priority logic and the instret counter.

Test Plan:
- LB: addr=0x1003, rdata=0x0011223380556677, rd=5 -> next cycle wb_en=1, wb_rd=5, wb_data=0xFFFFFFFFFFFFFF80. Same stimulus with LBU -> wb_data=0x0000000000000080.
- LW: addr=0x2004, rdata=0x80000001DEADBEEF -> wb_data=0xFFFFFFFF80000001. LWU -> 0x0000000080000001. LD at addr 0x2000 -> 0x80000001DEADBEEF.
- LH at addr=0x3001 -> load_fault=1 for exactly one cycle, fault_addr=0x3001, wb_en=0, instret increments. funct3=111 load -> identical fault behaviour.
- ALU op with rd=0, result=0x55 -> wb_valid=1, wb_en=0, instret increments. Same op with rd=7 -> wb_en=1, wb_data=0x55.
- Capture a load, then stall 3 cycles:
  - outputs hold, instret unchanged during the stall, load_fault does not re-pulse;
  - assert flush together with stall -> wb_valid=0 next cycle.
- Preload instret to 2^64-1 via a forced state, retire one instruction -> instret=0. Assert rst_n=0 mid-stream -> all outputs 0 on the next edge.
